// File: rtl/fpc_read_splitter.sv
// ---------------------------------------------------------------------------
// fpc_read_splitter
//   Splits per-channel host DMA regions (qword address + qword count) into
//   PCIe memory read requests for the TX block. Each request is at most
//   MAX_QW qwords and never crosses a 4 KB (512-qword) boundary. Channels
//   whose completion FIFO has a free slot are served round-robin, one
//   request at a time. The request tag {channel, tag_low} lets the FIFO
//   place the returning completion.
//
// Ports
//   clock, reset_n   core clock; asynchronous active-low reset
//   r_valid/r_ready  per-channel region handshake (r_ready = channel idle)
//   r_abort          per-channel discard of the remaining region
//   r_addr, r_count  region start (qword address) and length, shared
//   rr_valid         FIFO i has a free completion slot
//   rr_tag_low       slot id per FIFO, field i at [(i+1)*N-1 : i*N]
//   rr_ready         one-cycle pulse: slot of FIFO i consumed
//   rrm_*            read request to TX (valid/ready, addr, len, tag)
//   busy             channel i holds an unfinished region
// ---------------------------------------------------------------------------
module fpc_read_splitter #(
  parameter int NCH           = 4,
  parameter int NBITS_TAG_LOW = 3,
  parameter int MAX_QW        = 64
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NCH-1:0]               r_valid,
  output logic [NCH-1:0]               r_ready,
  input  logic [NCH-1:0]               r_abort,
  input  logic [60:0]                  r_addr,
  input  logic [18:0]                  r_count,
  input  logic [NCH-1:0]               rr_valid,
  input  logic [NCH*NBITS_TAG_LOW-1:0] rr_tag_low,
  output logic [NCH-1:0]               rr_ready,
  output logic                         rrm_valid,
  input  logic                         rrm_ready,
  output logic [60:0]                  rrm_addr,
  output logic [6:0]                   rrm_len,
  output logic [7:0]                   rrm_tag,
  output logic [NCH-1:0]               busy
);

  localparam logic [1:0] ST_ARB    = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  logic [1:0]     state;
  logic [1:0]     ptr;
  logic [1:0]     cur_ch;
  logic [9:0]     cur_len;
  logic           cur_void;   // granted channel was aborted after the grant

  logic [NCH-1:0] active;
  logic [60:0]    addr [NCH];
  logic [18:0]    rem  [NCH];

  logic [NCH-1:0] eligible;
  logic           grant_any;
  logic [1:0]     grant_ch;
  logic [60:0]    g_addr;
  logic [18:0]    g_rem;
  logic [9:0]     g_boundary;
  logic [9:0]     g_len;
  logic [7:0]     g_tag;

  assign r_ready  = ~active;
  assign busy     = active;
  assign eligible = active & rr_valid & ~r_abort;

  // Round-robin: first eligible channel at or after ptr, modulo NCH.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    int j;
    grant_any = 1'b0;
    grant_ch  = ptr;
    for (int k = 0; k < NCH; k++) begin
      j = int'(ptr) + k;
      if (j >= NCH) j -= NCH;
      if (!grant_any && eligible[j]) begin
        grant_any = 1'b1;
        grant_ch  = 2'(j);
      end
    end
  end

  // Request length: min(rem, MAX_QW, qwords left before the 4 KB boundary).
  always_comb begin
    g_addr     = addr[grant_ch];
    g_rem      = rem[grant_ch];
    g_boundary = 10'd512 - {1'b0, g_addr[8:0]};
    g_len      = 10'(MAX_QW);
    if (g_boundary < g_len)     g_len = g_boundary;
    if (g_rem < {9'd0, g_len})  g_len = g_rem[9:0];
    g_tag      = '0;
    g_tag[NBITS_TAG_LOW+1:0] =
      {grant_ch, rr_tag_low[grant_ch*NBITS_TAG_LOW +: NBITS_TAG_LOW]};
  end

  always_comb begin
    rr_ready = '0;
    if (state == ST_UPDATE) rr_ready[cur_ch] = 1'b1;
  end

  // Request FSM: ARB -> ISSUE -> UPDATE -> ARB.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ARB;
      ptr       <= '0;
      cur_ch    <= '0;
      cur_len   <= '0;
      cur_void  <= 1'b0;
      rrm_valid <= 1'b0;
      rrm_addr  <= '0;
      rrm_len   <= '0;
      rrm_tag   <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (grant_any) begin
            cur_ch    <= grant_ch;
            cur_len   <= g_len;
            cur_void  <= 1'b0;
            rrm_valid <= 1'b1;
            rrm_addr  <= g_addr;
            rrm_len   <= g_len[6:0];
            rrm_tag   <= g_tag;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // An abort cannot withdraw the valid; it only stops the update.
          if (r_abort[cur_ch]) cur_void <= 1'b1;
          if (rrm_ready) begin
            rrm_valid <= 1'b0;
            state     <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          ptr   <= (cur_ch == 2'(NCH - 1)) ? 2'd0 : cur_ch + 2'd1;
          state <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  // Per-channel region state. Abort beats a same-cycle load and the update.
  // A voided grant leaves the channel alone, so a region loaded after the
  // abort is not shortened by the old request.
  // NOTE: the per-channel addr/rem arrays are plain flops and are reset
  // with everything else, so the length mux never sees X.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active <= '0;
      for (int i = 0; i < NCH; i++) begin
        addr[i] <= '0;
        rem[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_abort[i]) begin
          active[i] <= 1'b0;
          rem[i]    <= '0;
        end else if (r_valid[i] && !active[i]) begin
          addr[i]   <= r_addr;
          rem[i]    <= r_count;
          active[i] <= (r_count != '0);
        end else if (state == ST_UPDATE && cur_ch == 2'(i) && !cur_void) begin
          addr[i]   <= addr[i] + 61'(cur_len);
          rem[i]    <= rem[i] - 19'(cur_len);
          active[i] <= (rem[i] != 19'(cur_len));
        end
      end
    end
  end

endmodule

// File: tb/tb_fpc_read_splitter.sv
`timescale 1ns/1ps
// Directed bench for fpc_read_splitter: region splitting, 4 KB split,
// round-robin, back-pressure, abort, zero count and async reset.
module tb_fpc_read_splitter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  r_valid, r_ready, r_abort;
  logic [60:0] r_addr;
  logic [18:0] r_count;
  logic [3:0]  rr_valid, rr_ready;
  logic [11:0] rr_tag_low;
  logic        rrm_valid, rrm_ready;
  logic [60:0] rrm_addr;
  logic [6:0]  rrm_len;
  logic [7:0]  rrm_tag;
  logic [3:0]  busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [60:0] addr;
    logic [6:0]  len;
    logic [7:0]  tag;
  } req_t;

  req_t req_q[$];
  int   rr_q[$];

  fpc_read_splitter #(.NCH(4), .NBITS_TAG_LOW(3), .MAX_QW(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .r_valid(r_valid), .r_ready(r_ready), .r_abort(r_abort),
    .r_addr(r_addr), .r_count(r_count),
    .rr_valid(rr_valid), .rr_tag_low(rr_tag_low), .rr_ready(rr_ready),
    .rrm_valid(rrm_valid), .rrm_ready(rrm_ready), .rrm_addr(rrm_addr),
    .rrm_len(rrm_len), .rrm_tag(rrm_tag), .busy(busy)
  );

  always #5 clock = ~clock;

  // Record accepted requests and rr_ready pulses, sampled mid-cycle.
  always @(negedge clock) begin
    req_t r;
    if (reset_n && rrm_valid && rrm_ready) begin
      r.addr = rrm_addr;
      r.len  = rrm_len;
      r.tag  = rrm_tag;
      req_q.push_back(r);
    end
    if (reset_n)
      for (int i = 0; i < 4; i++)
        if (rr_ready[i]) rr_q.push_back(i);
  end

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_tl(input int ch, input logic [2:0] v);
    rr_tag_low[ch*3 +: 3] = v;
  endtask

  task automatic load(input logic [3:0] mask, input logic [60:0] a,
                      input logic [18:0] c);
    @(posedge clock); #1;
    r_valid = mask; r_addr = a; r_count = c;
    @(posedge clock); #1;
    r_valid = '0;
  endtask

  task automatic expect_req(input string name, input logic [60:0] a,
                            input logic [6:0] l, input logic [7:0] t);
    int tmo = 0;
    req_t r;
    while (req_q.size() == 0 && tmo < 60) begin
      @(negedge clock);
      tmo++;
    end
    check({name, "_seen"}, 128'(req_q.size() != 0), 128'(1));
    if (req_q.size() != 0) begin
      r = req_q.pop_front();
      check({name, "_addr"}, 128'(r.addr), 128'(a));
      check({name, "_len"},  128'(r.len),  128'(l));
      check({name, "_tag"},  128'(r.tag),  128'(t));
    end
  endtask

  task automatic expect_rr(input string name, input int ch);
    int tmo = 0;
    while (rr_q.size() == 0 && tmo < 60) begin
      @(negedge clock);
      tmo++;
    end
    check({name, "_seen"}, 128'(rr_q.size() != 0), 128'(1));
    if (rr_q.size() != 0) check(name, 128'(rr_q.pop_front()), 128'(ch));
  endtask

  task automatic wait_valid(input string name);
    int tmo = 0;
    while (!rrm_valid && tmo < 20) begin
      @(negedge clock);
      tmo++;
    end
    check(name, 128'(rrm_valid), 128'(1));
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    req_q.delete();
    rr_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    r_valid = '0; r_abort = '0; r_addr = '0; r_count = '0;
    rr_valid = '0; rr_tag_low = '0; rrm_ready = 1'b0;

    // Reset state
    wait_cycles(2);
    check("rst_r_ready",   128'(r_ready),   128'(4'hF));
    check("rst_rrm_valid", 128'(rrm_valid), 128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_rr_ready",  128'(rr_ready),  128'(0));
    check("rst_fields",    128'({rrm_addr, rrm_len, rrm_tag}), 128'(0));
    @(posedge clock); #1 reset_n = 1'b1;

    // 1: ch0, byte 0x1000, 128 qwords -> two 64-qword requests
    rrm_ready = 1'b1;
    set_tl(0, 3'd5);
    rr_valid = 4'b0001;
    load(4'b0001, 61'h200, 19'd128);
    expect_req("t1_req0", 61'h200, 7'd64, 8'h05);
    expect_rr ("t1_rr0", 0);
    expect_req("t1_req1", 61'h240, 7'd64, 8'h05);
    expect_rr ("t1_rr1", 0);
    wait_cycles(2);
    check("t1_r_ready0", 128'(r_ready[0]), 128'(1));
    check("t1_busy0",    128'(busy[0]),    128'(0));
    check("t1_noextra",  128'(req_q.size()), 128'(0));

    // 2: ch1, qword 0x1F8, 20 qwords -> 8 up to the 4 KB line, then 12
    set_tl(1, 3'd2);
    rr_valid = 4'b0010;
    load(4'b0010, 61'h1F8, 19'd20);
    expect_req("t2_req0", 61'h1F8, 7'd8,  8'h0A);
    expect_rr ("t2_rr0", 1);
    expect_req("t2_req1", 61'h200, 7'd12, 8'h0A);
    expect_rr ("t2_rr1", 1);
    wait_cycles(2);
    check("t2_busy", 128'(busy), 128'(0));

    // 3: ch0 and ch2 both eligible from pointer 0 -> 0,2,0,2
    rr_valid = 4'b0000;
    do_reset();
    set_tl(0, 3'd3);
    set_tl(2, 3'd6);
    load(4'b0101, 61'h0, 19'd100);
    @(posedge clock); #1 rr_valid = 4'b0101;
    expect_req("t3_req0", 61'h00, 7'd64, 8'h03);
    expect_rr ("t3_rr0", 0);
    expect_req("t3_req1", 61'h00, 7'd64, 8'h16);
    expect_rr ("t3_rr1", 2);
    expect_req("t3_req2", 61'h40, 7'd36, 8'h03);
    expect_rr ("t3_rr2", 0);
    expect_req("t3_req3", 61'h40, 7'd36, 8'h16);
    expect_rr ("t3_rr3", 2);
    wait_cycles(2);
    check("t3_busy", 128'(busy), 128'(0));

    // 4: back-pressure, one-cycle grant latency, fields held stable
    rrm_ready = 1'b0;
    set_tl(0, 3'd1);
    rr_valid = 4'b0001;
    load(4'b0001, 61'h10, 19'd5);
    @(negedge clock);
    check("t4_lat0", 128'(rrm_valid), 128'(0));
    @(negedge clock);
    check("t4_lat1", 128'(rrm_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      check("t4_hold", 128'({rrm_valid, rrm_addr, rrm_len, rrm_tag, rr_ready}),
            128'({1'b1, 61'h10, 7'd5, 8'h01, 4'h0}));
      @(negedge clock);
    end
    check("t4_no_rr", 128'(rr_q.size()), 128'(0));
    @(posedge clock); #1 rrm_ready = 1'b1;
    expect_req("t4_req", 61'h10, 7'd5, 8'h01);
    expect_rr ("t4_rr", 0);
    wait_cycles(2);
    check("t4_busy", 128'(busy), 128'(0));

    // 5: abort ch0 while its request waits in ISSUE
    rrm_ready = 1'b0;
    set_tl(0, 3'd4);
    load(4'b0001, 61'h0, 19'd200);
    wait_valid("t5_valid");
    @(posedge clock); #1 r_abort = 4'b0001;
    @(posedge clock); #1 r_abort = 4'b0000;
    @(negedge clock);
    check("t5_busy_cleared", 128'(busy[0]),   128'(0));
    check("t5_valid_held",   128'(rrm_valid), 128'(1));
    @(posedge clock); #1 rrm_ready = 1'b1;
    expect_req("t5_req", 61'h0, 7'd64, 8'h04);
    expect_rr ("t5_rr", 0);
    wait_cycles(10);
    check("t5_no_more", 128'(req_q.size()), 128'(0));
    check("t5_r_ready", 128'(r_ready),      128'(4'hF));

    // Abort and load on the same cycle: the region is not taken
    rr_valid = 4'b0010;
    @(posedge clock); #1;
    r_valid = 4'b0010; r_abort = 4'b0010; r_addr = 61'h0; r_count = 19'd50;
    @(posedge clock); #1;
    r_valid = '0; r_abort = '0;
    wait_cycles(5);
    check("t5b_busy", 128'(busy),          128'(0));
    check("t5b_noreq", 128'(req_q.size()), 128'(0));

    // Zero count: consumed, nothing issued
    rr_valid = 4'b1000;
    load(4'b1000, 61'h123, 19'd0);
    wait_cycles(5);
    check("t5c_busy",  128'(busy),          128'(0));
    check("t5c_noreq", 128'(req_q.size()),  128'(0));

    // 6: async reset mid-ISSUE; arbitration restarts at ch0
    set_tl(2, 3'd7);
    rr_valid = 4'b0100;
    load(4'b0100, 61'h3C, 19'd4);
    expect_req("t6_pre", 61'h3C, 7'd4, 8'h17);
    expect_rr ("t6_pre_rr", 2);
    wait_cycles(2);
    rrm_ready = 1'b0;
    load(4'b0100, 61'h80, 19'd8);
    wait_valid("t6_valid");
    set_tl(0, 3'd2);
    set_tl(3, 3'd1);
    rr_valid = 4'b1001;
    @(posedge clock); #3 reset_n = 1'b0;
    #1;
    check("t6_rst_valid",   128'(rrm_valid), 128'(0));
    check("t6_rst_r_ready", 128'(r_ready),   128'(4'hF));
    check("t6_rst_busy",    128'(busy),      128'(0));
    check("t6_rst_rr",      128'(rr_ready),  128'(0));
    @(posedge clock); #1 reset_n = 1'b1;
    req_q.delete();
    rr_q.delete();
    rrm_ready = 1'b1;
    load(4'b1001, 61'h1000, 19'd2);
    expect_req("t6_req0", 61'h1000, 7'd2, 8'h02);
    expect_rr ("t6_rr0", 0);
    expect_req("t6_req1", 61'h1000, 7'd2, 8'h19);
    expect_rr ("t6_rr1", 3);
    wait_cycles(2);
    check("t6_busy", 128'(busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
